// File: rtl/md_scheduler_pkg.sv
// md_scheduler_pkg: shared definitions for the multiply/divide scheduler.
// It holds the MD operation codes, the default latencies, the Tuse values the
// hazard unit reads for MD-class instructions, and small op-class helpers.
package md_scheduler_pkg;

  localparam int unsigned MDOP_SIZE = 4;

  typedef enum logic [MDOP_SIZE-1:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MTHI  = 4'd5,
    MDOP_MTLO  = 4'd6,
    MDOP_MFHI  = 4'd7,
    MDOP_MFLO  = 4'd8
  } md_op_e;

  // Busy durations when the instantiating level does not override them.
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  // Operand use times for MD instructions, in the hazard unit's T encoding.
  localparam int unsigned T_SIZE     = 2;
  localparam logic [T_SIZE-1:0] TUSE_MD_RS = 2'd1;
  localparam logic [T_SIZE-1:0] TUSE_MD_RT = 2'd1;

  // Long ops occupy the unit for several cycles and write HI and LO together.
  function automatic logic is_long_op(input md_op_e op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

  function automatic logic is_mult_op(input md_op_e op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// md_scheduler_if: E/D-stage request and HI/LO result signals of the MD unit.
// The pipeline side is the master, the scheduler is the slave.
interface md_scheduler_if;
  import md_scheduler_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  modport master (
    output start, md_op, rs_val, rt_val, d_is_md,
    input  busy, stall, hi, lo, md_rdata
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, d_is_md,
    output busy, stall, hi, lo, md_rdata
  );

endinterface

// File: rtl/md_scheduler_arith.sv
// md_arith: combinational 64-bit {hi, lo} result for mult/multu/div/divu,
// including the divide-by-zero and signed-overflow results.
module md_arith
  import md_scheduler_pkg::*;
(
  input  md_op_e      i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result
);

  logic               w_div_zero;
  logic               w_div_ovf;
  logic signed [63:0] w_a_sext;
  logic signed [63:0] w_b_sext;
  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic signed [31:0] w_b_sdiv;
  logic signed [31:0] w_squot;
  logic signed [31:0] w_srem;
  logic        [31:0] w_b_udiv;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;

  assign w_div_zero = (i_b == 32'd0);
  assign w_div_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Operands widened explicitly so each product is a plain 64x64 multiply.
  assign w_a_sext = {{32{i_a[31]}}, i_a};
  assign w_b_sext = {{32{i_b[31]}}, i_b};
  assign w_smul   = w_a_sext * w_b_sext;
  assign w_umul   = {32'd0, i_a} * {32'd0, i_b};

  // The dividers never see zero or the overflowing -1: dividing by 1 instead
  // keeps them well defined and yields exactly the overflow answer (a, rem 0).
  assign w_b_sdiv = (w_div_zero || w_div_ovf) ? 32'sd1 : $signed(i_b);
  assign w_squot  = $signed(i_a) / w_b_sdiv;
  assign w_srem   = $signed(i_a) % w_b_sdiv;
  assign w_b_udiv = w_div_zero ? 32'd1 : i_b;
  assign w_uquot  = i_a / w_b_udiv;
  assign w_urem   = i_a % w_b_udiv;

  // Select the result for the requested long op.
  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    o_result = 64'd0;
    unique case (i_op)
      MDOP_MULT:  o_result = w_smul;
      MDOP_MULTU: o_result = w_umul;
      MDOP_DIV:   o_result = w_div_zero ? {i_a, 32'hFFFF_FFFF}
                                        : {w_srem, w_squot};
      MDOP_DIVU:  o_result = w_div_zero ? {i_a, 32'hFFFF_FFFF}
                                        : {w_urem, w_uquot};
      default:    o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: owns HI/LO, sequences multi-cycle mult/div with a fixed busy
// latency, raises the D-stage stall request and serves mfhi/mflo reads.
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  md_scheduler_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;

  logic [63:0] w_result;
  logic [3:0]  w_load_cnt;
  logic        w_issue_long;

  md_arith u_arith (
    .i_op     (bus.md_op),
    .i_a      (bus.rs_val),
    .i_b      (bus.rt_val),
    .o_result (w_result)
  );

  assign w_issue_long = bus.start && is_long_op(bus.md_op);
  assign w_load_cnt   = is_mult_op(bus.md_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);

  // FSM: issue long ops and mt writes from IDLE, count down and commit in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values held before this edge, independent of statement order.
      unique case (r_state)
        ST_IDLE: begin
          if (w_issue_long) begin
            r_pend_hi <= w_result[63:32];
            r_pend_lo <= w_result[31:0];
            r_cnt     <= w_load_cnt;
            r_busy    <= 1'b1;
            r_state   <= ST_RUN;
          end else if (bus.start && (bus.md_op == MDOP_MTHI)) begin
            r_hi <= bus.rs_val;
          end else if (bus.start && (bus.md_op == MDOP_MTLO)) begin
            r_lo <= bus.rs_val;
          end
        end
        ST_RUN: begin
          // Any start while running is dropped; the hazard unit prevents it.
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // mfhi/mflo read port for the E-stage result mux.
  always_comb begin
    bus.md_rdata = 32'd0;
    if (bus.md_op == MDOP_MFHI) bus.md_rdata = r_hi;
    else if (bus.md_op == MDOP_MFLO) bus.md_rdata = r_lo;
  end

  // The issue cycle stalls too, since busy only rises at the following edge.
  assign bus.stall = bus.d_is_md && (r_busy || w_issue_long);
  assign bus.busy  = r_busy;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multiply/divide scheduler for the 5-stage MIPS pipeline. It owns the HI/LO registers and sequences multi-cycle mult/multu/div/divu.
- Accepts one operation per start pulse from the E stage and holds busy for a fixed latency.
- Generates the D-stage stall request when an MD-class instruction must wait.
- Serves mfhi/mflo reads to the E-stage result mux.

Parameters:
MULT_CYCLES, 5, busy duration in cycles for mult/multu (range 1..15)
DIV_CYCLES, 10, busy duration in cycles for div/divu (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E-stage instruction is MD-class and valid this cycle
md_op  input  MDOP_SIZE(4)  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, NONE
rs_val  input  32  forwarded rs operand from the E stage
rt_val  input  32  forwarded rt operand from the E stage
d_is_md  input  1  D-stage instruction is any MD-class op (set by the control decoder)
busy  output  1  long operation in flight
stall  output  1  stall request to the hazard unit
hi  output  32  architectural HI
lo  output  32  architectural LO
md_rdata  output  32  hi when md_op=MFHI, lo when md_op=MFLO, else 0 (combinational)

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - busy=0, counter=0, hi=0, lo=0, pending registers=0.
  - An aborted operation never commits.
- States: IDLE, RUN.
- IDLE, start=1 with md_op in {MULT, MULTU, DIV, DIVU}:
  - Latch the full 64-bit result into pend_hi/pend_lo at the edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from that edge.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1: hi<=pend_hi, lo<=pend_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles, and the new hi/lo are visible in the same cycle busy drops.
- MTHI/MTLO with start=1 in IDLE: hi<=rs_val or lo<=rs_val at the next edge; no busy.
- MFHI/MFLO: purely combinational read of the current hi/lo; no state change.
- start=1 while busy=1:
  - Ignored: no write, counter unchanged.
  - The hazard unit makes this unreachable; the bench asserts it never occurs.
- stall = d_is_md & (busy | (start & md_op in {MULT, MULTU, DIV, DIVU})).
  - This covers the cycle a long op issues, before busy rises.
- Arithmetic:
  - MULT: signed 32x32->64, hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32->64, hi=[63:32], lo=[31:0].
  - DIV: signed, lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned, lo=quotient, hi=remainder.
  - Divide by zero (rt_val=0): lo=32'hFFFFFFFF, hi=rs_val, for both signed and unsigned.
  - Signed overflow 0x80000000/-1: lo=0x80000000, hi=0.
- md_op=NONE or start=0: no effect.

Decomposition:
- Shared macros file:
  - MDOP_SIZE and the MDOP_* codes.
  - Default MULT_CYCLES/DIV_CYCLES values.
  - T_SIZE-compatible Tuse values for MD ops: rs=1, rt=1.
- One natural sub-module: md_arith, a combinational 64-bit result generator covering the four long ops and the div-by-zero/overflow rules.
- md_scheduler keeps the counter, FSM, HI/LO and stall logic.

Test Plan:
- Reset mid-run, then mthi: mult 3 x 5, assert reset at cycle 2 -> busy=0, hi=lo=0 immediately; then mthi rs=0x1234 -> hi=0x00001234 next cycle, busy stays 0.
- Signed vs unsigned multiply: mult rs=3, rt=0xFFFFFFFE -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Signed divide: div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide edge cases: divu rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall window: start mult with d_is_md=1 held -> stall=1 on the issue cycle and all 5 busy cycles, 0 on the cycle after busy falls. With d_is_md=0 -> stall=0 throughout.
- Read during run: mflo during a run returns the old lo (e.g. 0xFFFFFFFA). mflo after the 10-cycle div returns the new quotient.
